axi_lite_strb_slave: RTL and testbench

Parametrised AXI4-Lite slave that converts bus transactions into simple request/acknowledge register accesses for user logic.
- Generalises data width and adds byte-strobe pass-through.
- Read and write paths are fully independent and run concurrently.
- AW and W are accepted in either order.
- A user-response timeout returns SLVERR.
- Sits between the interconnect and a peripheral's register file.

---
 rtl/axi_lite_strb_slave_pkg.sv | 20 ++
 rtl/axi_lite_timeout_ctr.sv | 36 +++
 rtl/axi_lite_strb_slave.sv | 210 +++++++++++++++++++++
 tb/tb_axi_lite_strb_slave.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_strb_slave_pkg.sv
// Shared response codes and width derivations for the AXI4-Lite strobe slave.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package axi_lite_strb_slave_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // One strobe bit per data byte.
   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

   // Number of byte-offset address bits cleared to word-align user addresses.
   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// Counts cycles spent waiting for a user ack and flags expiry.
// Latency: expire is combinational from the count; fires in the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; TIMEOUT_CYCLES=0 means expire never asserts.
module axi_lite_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_never
         assign expire = 1'b0;
      end else begin : g_count
         localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
         logic [CW-1:0] cnt;

         // Cycle counter: held at zero while cleared, advances while enabled.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt <= '0;
            end else if (clr) begin
               cnt <= '0;
            end else if (en) begin
               cnt <= cnt + 1'b1;
            end
         end

         assign expire = en && !clr && (cnt == CW'(TIMEOUT_CYCLES - 1));
      end
   endgenerate

endmodule

// File: rtl/axi_lite_strb_slave.sv
// AXI4-Lite slave turning bus reads/writes into req/ack user register accesses with byte strobes.
// Latency: user req 1 cycle after the last AW/W/AR handshake; bvalid/rvalid 1 cycle after the user ack.
// Backpressure: one outstanding access per path; readies stay low until bready/rready completes it.
module axi_lite_strb_slave
   import axi_lite_strb_slave_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int STRB_WIDTH    = strb_width(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_awvalid,
   output logic                  o_awready,
   input  logic [ADDR_WIDTH-1:0] i_awaddr,
   input  logic                  i_wvalid,
   output logic                  o_wready,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [STRB_WIDTH-1:0] i_wstrb,
   output logic                  o_bvalid,
   input  logic                  i_bready,
   output logic [1:0]            o_bresp,
   input  logic                  i_arvalid,
   output logic                  o_arready,
   input  logic [ADDR_WIDTH-1:0] i_araddr,
   output logic                  o_rvalid,
   input  logic                  i_rready,
   output logic [1:0]            o_rresp,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_wr_req,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic [DATA_WIDTH-1:0] o_wr_data,
   output logic [STRB_WIDTH-1:0] o_wr_strb,
   input  logic                  i_wr_ack_stb,
   input  logic                  i_wr_invalid_addr,
   output logic                  o_rd_req,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   input  logic                  i_rd_ack_stb,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   input  logic                  i_rd_invalid_addr
);

   localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ADDR_LSB;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_USER = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_USER = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   logic [1:0]            wstate;
   logic [1:0]            rstate;
   logic                  have_aw;
   logic                  have_w;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  have_aw_n;
   logic                  have_w_n;
   logic [STRB_WIDTH-1:0] strb_n;
   logic                  wr_expire;
   logic                  rd_expire;

   assign aw_hs     = i_awvalid && o_awready;
   assign w_hs      = i_wvalid && o_wready;
   assign have_aw_n = have_aw || aw_hs;
   assign have_w_n  = have_w || w_hs;
   assign strb_n    = w_hs ? i_wstrb : o_wr_strb;

   axi_lite_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (wstate != W_USER),
      .en     (wstate == W_USER),
      .expire (wr_expire)
   );

   axi_lite_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (rstate != R_USER),
      .en     (rstate == R_USER),
      .expire (rd_expire)
   );

   // Write path: collect AW and W in any order, run the user access, then return B.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate    <= W_IDLE;
         have_aw   <= 1'b0;
         have_w    <= 1'b0;
         o_awready <= 1'b0;
         o_wready  <= 1'b0;
         o_wr_req  <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         o_wr_strb <= '0;
         o_bvalid  <= 1'b0;
         o_bresp   <= RESP_OKAY;
      end else begin
         case (wstate)
            W_IDLE: begin
               if (aw_hs) begin
                  o_wr_addr <= i_awaddr & ADDR_MASK;
               end
               if (w_hs) begin
                  o_wr_data <= i_wdata;
                  o_wr_strb <= i_wstrb;
               end
               if (have_aw_n && have_w_n) begin
                  have_aw   <= 1'b0;
                  have_w    <= 1'b0;
                  o_awready <= 1'b0;
                  o_wready  <= 1'b0;
                  // An all-zero strobe writes nothing, so skip the user side.
                  if (strb_n == '0) begin
                     o_bresp  <= RESP_OKAY;
                     o_bvalid <= 1'b1;
                     wstate   <= W_RESP;
                  end else begin
                     o_wr_req <= 1'b1;
                     wstate   <= W_USER;
                  end
               end else begin
                  have_aw   <= have_aw_n;
                  have_w    <= have_w_n;
                  o_awready <= !have_aw_n;
                  o_wready  <= !have_w_n;
               end
            end
            W_USER: begin
               // The ack takes priority over a timeout landing in the same cycle.
               if (i_wr_ack_stb) begin
                  o_wr_req <= 1'b0;
                  o_bresp  <= i_wr_invalid_addr ? RESP_DECERR : RESP_OKAY;
                  o_bvalid <= 1'b1;
                  wstate   <= W_RESP;
               end else if (wr_expire) begin
                  o_wr_req <= 1'b0;
                  o_bresp  <= RESP_SLVERR;
                  o_bvalid <= 1'b1;
                  wstate   <= W_RESP;
               end
            end
            W_RESP: begin
               if (i_bready) begin
                  o_bvalid  <= 1'b0;
                  o_awready <= 1'b1;
                  o_wready  <= 1'b1;
                  wstate    <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   // Read path: accept AR, run the user access, then hold R until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rstate    <= R_IDLE;
         o_arready <= 1'b0;
         o_rd_req  <= 1'b0;
         o_rd_addr <= '0;
         o_rvalid  <= 1'b0;
         o_rresp   <= RESP_OKAY;
         o_rdata   <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (i_arvalid && o_arready) begin
                  o_rd_addr <= i_araddr & ADDR_MASK;
                  o_arready <= 1'b0;
                  o_rd_req  <= 1'b1;
                  rstate    <= R_USER;
               end else begin
                  o_arready <= 1'b1;
               end
            end
            R_USER: begin
               if (i_rd_ack_stb) begin
                  o_rd_req <= 1'b0;
                  o_rdata  <= i_rd_data;
                  o_rresp  <= i_rd_invalid_addr ? RESP_DECERR : RESP_OKAY;
                  o_rvalid <= 1'b1;
                  rstate   <= R_DATA;
               end else if (rd_expire) begin
                  o_rd_req <= 1'b0;
                  o_rdata  <= '0;
                  o_rresp  <= RESP_SLVERR;
                  o_rvalid <= 1'b1;
                  rstate   <= R_DATA;
               end
            end
            R_DATA: begin
               if (i_rready) begin
                  o_rvalid  <= 1'b0;
                  o_arready <= 1'b1;
                  rstate    <= R_IDLE;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_strb_slave.sv
// Directed bench for axi_lite_strb_slave: vector table plus hand-written corner sequences.
// Main instance uses a short timeout; a 64-bit instance repeats the basic write.
// All stimulus is applied and all outputs sampled on the falling clock edge.
module tb_axi_lite_strb_slave;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [15:0] awaddr, araddr, wr_addr, rd_addr;
   logic [31:0] wdata, rdata, wr_data, rd_data;
   logic [3:0]  wstrb, wr_strb;
   logic [1:0]  bresp, rresp;
   logic        arvalid, arready, rvalid, rready;
   logic        wr_req, wr_ack, wr_inv, rd_req, rd_ack, rd_inv;

   logic        d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
   logic [15:0] d_awaddr, d_wr_addr, d_rd_addr;
   logic [63:0] d_wdata, d_rdata, d_wr_data;
   logic [7:0]  d_wstrb, d_wr_strb;
   logic [1:0]  d_bresp, d_rresp;
   logic        d_arready, d_rvalid, d_wr_req, d_wr_ack, d_rd_req;

   axi_lite_strb_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr),
      .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
      .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
      .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
      .o_rvalid(rvalid), .i_rready(rready), .o_rresp(rresp), .o_rdata(rdata),
      .o_wr_req(wr_req), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_wr_strb(wr_strb),
      .i_wr_ack_stb(wr_ack), .i_wr_invalid_addr(wr_inv),
      .o_rd_req(rd_req), .o_rd_addr(rd_addr),
      .i_rd_ack_stb(rd_ack), .i_rd_data(rd_data), .i_rd_invalid_addr(rd_inv)
   );

   axi_lite_strb_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .TIMEOUT_CYCLES(256)) dut64 (
      .clk(clk), .rst(rst),
      .i_awvalid(d_awvalid), .o_awready(d_awready), .i_awaddr(d_awaddr),
      .i_wvalid(d_wvalid), .o_wready(d_wready), .i_wdata(d_wdata), .i_wstrb(d_wstrb),
      .o_bvalid(d_bvalid), .i_bready(d_bready), .o_bresp(d_bresp),
      .i_arvalid(1'b0), .o_arready(d_arready), .i_araddr(16'h0000),
      .o_rvalid(d_rvalid), .i_rready(1'b0), .o_rresp(d_rresp), .o_rdata(d_rdata),
      .o_wr_req(d_wr_req), .o_wr_addr(d_wr_addr), .o_wr_data(d_wr_data), .o_wr_strb(d_wr_strb),
      .i_wr_ack_stb(d_wr_ack), .i_wr_invalid_addr(1'b0),
      .o_rd_req(d_rd_req), .o_rd_addr(d_rd_addr),
      .i_rd_ack_stb(1'b0), .i_rd_data(64'h0), .i_rd_invalid_addr(1'b0)
   );

   // order: 0 = AW then W three cycles later, 1 = W then AW, 2 = same cycle.
   // dly: req-high cycles before the ack is driven; -1 = never ack.
   typedef struct {
      bit          rd;
      int          order;
      logic [15:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      bit          inv;
      int          dly;
      int          hold;
      logic [15:0] exp_addr;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wr_txn(input vec_t v);
      int n;
      bit seen_req;
      @(negedge clk);
      awaddr = v.addr; wdata = v.data; wstrb = v.strb;
      if (v.order == 2) begin
         awvalid = 1'b1; wvalid = 1'b1;
         n = 0;
         while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
         chk("aw_w_rdy", {62'd0, awready, wready}, 64'd3);
         @(negedge clk);
         awvalid = 1'b0; wvalid = 1'b0;
      end else begin
         for (int ph = 0; ph < 2; ph++) begin
            if ((ph == 0) == (v.order == 0)) begin
               awvalid = 1'b1;
               n = 0;
               while (!awready && n < 20) begin @(negedge clk); n++; end
               chk("aw_rdy", awready, 1);
               @(negedge clk);
               awvalid = 1'b0;
            end else begin
               wvalid = 1'b1;
               n = 0;
               while (!wready && n < 20) begin @(negedge clk); n++; end
               chk("w_rdy", wready, 1);
               @(negedge clk);
               wvalid = 1'b0;
            end
            if (ph == 0 && v.order == 0) repeat (2) @(negedge clk);
         end
      end
      if (v.strb == 4'b0000) begin
         seen_req = 1'b0;
         n = 0;
         while (!bvalid && n < 2) begin
            if (wr_req) seen_req = 1'b1;
            @(negedge clk);
            n++;
         end
         if (wr_req) seen_req = 1'b1;
         chk("wr_noreq_strb0", seen_req, 0);
      end else begin
         chk("wr_req_rise", wr_req, 1);
         chk("wr_addr", wr_addr, v.exp_addr);
         chk("wr_data", wr_data, v.data);
         chk("wr_strb", wr_strb, v.strb);
         if (v.dly >= 0) begin
            repeat (v.dly) begin @(negedge clk); chk("wr_req_hold", wr_req, 1); end
            wr_ack = 1'b1; wr_inv = v.inv;
            @(negedge clk);
            wr_ack = 1'b0; wr_inv = 1'b0;
         end else begin
            n = 0;
            while (wr_req && n < 300) begin @(negedge clk); n++; end
            chk("wr_timeout_cycles", n, 8);
         end
         chk("wr_req_drop", wr_req, 0);
      end
      chk("bvalid_rise", bvalid, 1);
      chk("bresp", bresp, v.exp_resp);
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("bvalid_single", bvalid, 0);
      chk("w_readies_back", {62'd0, awready, wready}, 64'd3);
   endtask

   task automatic rd_txn(input vec_t v);
      int n;
      @(negedge clk);
      arvalid = 1'b1; araddr = v.addr;
      n = 0;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      chk("ar_rdy", arready, 1);
      @(negedge clk);
      arvalid = 1'b0;
      chk("rd_req_rise", rd_req, 1);
      chk("rd_addr", rd_addr, v.exp_addr);
      if (v.dly >= 0) begin
         repeat (v.dly) begin @(negedge clk); chk("rd_req_hold", rd_req, 1); end
         rd_ack = 1'b1; rd_data = v.data; rd_inv = v.inv;
         @(negedge clk);
         rd_ack = 1'b0; rd_data = 32'h0; rd_inv = 1'b0;
      end else begin
         n = 0;
         while (rd_req && n < 300) begin @(negedge clk); n++; end
         chk("rd_timeout_cycles", n, 8);
      end
      chk("rd_req_drop", rd_req, 0);
      chk("rvalid_rise", rvalid, 1);
      chk("rresp", rresp, v.exp_resp);
      chk("rdata", rdata, v.exp_rdata);
      repeat (v.hold) begin
         @(negedge clk);
         chk("rvalid_stable", rvalid, 1);
         chk("rdata_stable", rdata, v.exp_rdata);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk("rvalid_drop", rvalid, 0);
      chk("arready_back", arready, 1);
   endtask

   vec_t tbl[10];
   vec_t vw, vr;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit seen;
      //           rd order addr      data          strb  inv dly hold exp_addr  resp    exp_rdata
      tbl[0] = '{0, 0, 16'h0000, 32'hDEADBEEF, 4'b0011, 0,  2, 0, 16'h0000, OKAY,   32'h0};
      tbl[1] = '{0, 1, 16'h0007, 32'hA5A50001, 4'b1111, 0,  0, 0, 16'h0004, OKAY,   32'h0};
      tbl[2] = '{0, 2, 16'h0007, 32'hA5A50001, 4'b1111, 0,  0, 0, 16'h0004, OKAY,   32'h0};
      tbl[3] = '{0, 2, 16'h0020, 32'h11112222, 4'b0000, 0,  0, 0, 16'h0020, OKAY,   32'h0};
      tbl[4] = '{0, 0, 16'h0013, 32'h0BADF00D, 4'b1000, 1,  1, 0, 16'h0010, DECERR, 32'h0};
      tbl[5] = '{1, 0, 16'h0010, 32'h12345678, 4'b0000, 1,  1, 5, 16'h0010, DECERR, 32'h12345678};
      tbl[6] = '{1, 0, 16'h0022, 32'hFFFFFFFF, 4'b0000, 0, -1, 1, 16'h0020, SLVERR, 32'h0};
      tbl[7] = '{1, 0, 16'h0031, 32'hCAFEF00D, 4'b0000, 0,  7, 0, 16'h0030, OKAY,   32'hCAFEF00D};
      tbl[8] = '{0, 2, 16'h0044, 32'h55AA55AA, 4'b0101, 0, -1, 0, 16'h0044, SLVERR, 32'h0};
      tbl[9] = '{0, 2, 16'h0048, 32'h01020304, 4'b0110, 0,  7, 0, 16'h0048, OKAY,   32'h0};

      rst = 1'b1;
      awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
      arvalid = 0; araddr = 0; rready = 0;
      wr_ack = 0; wr_inv = 0; rd_ack = 0; rd_data = 0; rd_inv = 0;
      d_awvalid = 0; d_awaddr = 0; d_wvalid = 0; d_wdata = 0; d_wstrb = 0;
      d_bready = 0; d_wr_ack = 0;

      repeat (2) @(negedge clk);
      chk("rst_readies", {61'd0, awready, wready, arready}, 64'd0);
      chk("rst_valids", {62'd0, bvalid, rvalid}, 64'd0);
      chk("rst_reqs", {62'd0, wr_req, rd_req}, 64'd0);
      chk("rst_rdata", rdata, 0);
      chk("rst_wr_addr", wr_addr, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("readies_after_rst", {61'd0, awready, wready, arready}, 64'd7);

      for (int i = 0; i < 10; i++) begin
         if (tbl[i].rd) rd_txn(tbl[i]);
         else wr_txn(tbl[i]);
      end

      // Concurrent read and write with acks landing in the same cycle.
      vw = '{0, 2, 16'h0052, 32'h87654321, 4'b1100, 0, 1, 0, 16'h0050, OKAY, 32'h0};
      vr = '{1, 0, 16'h0063, 32'h13579BDF, 4'b0000, 0, 1, 2, 16'h0060, OKAY, 32'h13579BDF};
      fork
         wr_txn(vw);
         rd_txn(vr);
      join

      // Reset while a write is waiting in the user phase: abandoned, no response.
      @(negedge clk);
      awvalid = 1'b1; wvalid = 1'b1; awaddr = 16'h0070; wdata = 32'hFEEDFACE; wstrb = 4'b1111;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("rstmid_req_before", wr_req, 1);
      rst = 1'b1;
      #1;
      chk("rstmid_req", wr_req, 0);
      chk("rstmid_readies", {62'd0, awready, wready}, 64'd0);
      chk("rstmid_wr_data", wr_data, 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bvalid || wr_req) seen = 1'b1;
      end
      chk("rstmid_no_bvalid", seen, 0);
      chk("rstmid_readies_back", {62'd0, awready, wready}, 64'd3);

      // 64-bit instance: AW, then W three cycles later, ack two cycles after req.
      @(negedge clk);
      chk("d64_awready", d_awready, 1);
      d_awvalid = 1'b1; d_awaddr = 16'h000F;
      @(negedge clk);
      d_awvalid = 1'b0;
      repeat (2) @(negedge clk);
      chk("d64_wready", d_wready, 1);
      d_wvalid = 1'b1; d_wdata = 64'h0000_0000_DEAD_BEEF; d_wstrb = 8'b0000_0011;
      @(negedge clk);
      d_wvalid = 1'b0;
      chk("d64_req", d_wr_req, 1);
      chk("d64_addr", d_wr_addr, 16'h0008);
      chk("d64_data", d_wr_data, 64'h0000_0000_DEAD_BEEF);
      chk("d64_strb", d_wr_strb, 8'b0000_0011);
      repeat (2) @(negedge clk);
      d_wr_ack = 1'b1;
      @(negedge clk);
      d_wr_ack = 1'b0;
      chk("d64_bvalid", d_bvalid, 1);
      chk("d64_bresp", d_bresp, OKAY);
      d_bready = 1'b1;
      @(negedge clk);
      d_bready = 1'b0;
      chk("d64_bvalid_single", d_bvalid, 0);
      n = 0;
      if (d_rvalid || d_rd_req || (d_rdata != 64'h0) || (d_rresp != OKAY) || (d_rd_addr != 16'h0)) n = 1;
      chk("d64_read_idle", n, 0);
      chk("d64_arready", d_arready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
